// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types.
//   word_t      : 32-bit data/address word
//   ramstate_t  : RAM model handshake state (FREE/BUSY/ACCESS/ERROR)
//   arb_state_t : RAM arbiter FSM state (IDLE/GRANT)
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// Bus between the requesters, the RAM arbiter and the RAM model.
//   req_ren/req_wen/req_lock/req_addr/req_store : requester -> arbiter
//   req_wait/req_load                           : arbiter -> requester
//   ramREN/ramWEN/ramaddr/ramstore              : arbiter -> RAM
//   ramload/ramstate                            : RAM -> arbiter
//   gnt_valid/gnt_id/ram_err                    : arbiter status
// Modports: slave = arbiter view, master = requesters + RAM view.
interface ram_arbiter_if
    import cpu_types_pkg::*;
#(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]         req_ren;
    logic [NREQ-1:0]         req_wen;
    logic [NREQ-1:0]         req_lock;
    word_t [NREQ-1:0]        req_addr;
    word_t [NREQ-1:0]        req_store;
    logic [NREQ-1:0]         req_wait;
    word_t [NREQ-1:0]        req_load;
    logic                    ramREN;
    logic                    ramWEN;
    word_t                   ramaddr;
    word_t                   ramstore;
    word_t                   ramload;
    ramstate_t               ramstate;
    logic                    gnt_valid;
    logic [$clog2(NREQ)-1:0] gnt_id;
    logic                    ram_err;

    modport slave (
        input  req_ren, req_wen, req_lock, req_addr, req_store, ramload, ramstate,
        output req_wait, req_load, ramREN, ramWEN, ramaddr, ramstore,
               gnt_valid, gnt_id, ram_err
    );

    modport master (
        output req_ren, req_wen, req_lock, req_addr, req_store, ramload, ramstate,
        input  req_wait, req_load, ramREN, ramWEN, ramaddr, ramstore,
               gnt_valid, gnt_id, ram_err
    );
endinterface

// File: rtl/rr_picker.sv
// Rotating-priority encoder: returns the first set bit of req at or after
// index ptr, wrapping modulo NREQ.
//   req   : request vector
//   ptr   : highest-priority index this round
//   found : some request is set
//   idx   : chosen index (0 when nothing is found)
module rr_picker #(
    parameter int NREQ  = 4,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        found = 1'b0;
        idx   = '0;
        // Walk from the farthest offset down so the closest requester after ptr wins.
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % NREQ]) begin
                found = 1'b1;
                idx   = IDX_W'((int'(ptr) + k) % NREQ);
            end
        end
    end
endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one RAM port between NREQ requesters.
// One grant is registered at a time and held until the RAM reports ACCESS;
// a grantee asserting req_lock keeps the port for up to MAXBURST accesses.
//   CLK  : clock, rising edge
//   nRST : asynchronous active-low reset
//   bus  : ram_arbiter_if.slave (requester side, RAM side, grant status)
module ram_arbiter
    import cpu_types_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int MAXBURST = 4
) (
    input  logic          CLK,
    input  logic          nRST,
    ram_arbiter_if.slave  bus
);
    localparam int IDX_W = $clog2(NREQ);
    localparam int CNT_W = $clog2(MAXBURST + 1);

    arb_state_t       state, state_d;
    logic [IDX_W-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0] rr_ptr, rr_ptr_d;
    logic [CNT_W-1:0] burst_cnt, burst_cnt_d;

    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic             g_active;
    logic             g_lock;
    logic [IDX_W-1:0] gnt_next;

    rr_picker #(.NREQ(NREQ), .IDX_W(IDX_W)) u_picker (
        .req   (bus.req_ren | bus.req_wen),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign g_active = bus.req_ren[gnt_q] | bus.req_wen[gnt_q];
    assign g_lock   = bus.req_lock[gnt_q];
    assign gnt_next = (gnt_q == IDX_W'(NREQ - 1)) ? '0 : gnt_q + IDX_W'(1);

    // State register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            gnt_q     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state     <= state_d;
            gnt_q     <= gnt_d;
            rr_ptr    <= rr_ptr_d;
            burst_cnt <= burst_cnt_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d     = state;
        gnt_d       = gnt_q;
        rr_ptr_d    = rr_ptr;
        burst_cnt_d = burst_cnt;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_d     = GRANT;
                    gnt_d       = pick_idx;
                    burst_cnt_d = '0;
                end
            end
            GRANT: begin
                if (!g_active) begin
                    // Grantee withdrew before its access completed: give up the port.
                    state_d  = IDLE;
                    rr_ptr_d = gnt_next;
                end else if (bus.ramstate == ACCESS) begin
                    if (g_lock && (int'(burst_cnt) < MAXBURST - 1)) begin
                        burst_cnt_d = burst_cnt + CNT_W'(1);
                    end else begin
                        state_d  = IDLE;
                        rr_ptr_d = gnt_next;
                    end
                end
                // ERROR/BUSY/FREE: hold the grant and keep the enables asserted.
            end
        endcase
    end

    // Output logic: enables are combinational from the registered grant so an
    // async reset or a withdrawn request drops them within the same cycle.
    always_comb begin
        logic granted;
        logic completing;
        granted        = (state == GRANT);
        completing     = granted && (bus.ramstate == ACCESS);
        bus.gnt_valid  = granted;
        bus.gnt_id     = gnt_q;
        bus.ram_err    = granted && (bus.ramstate == ERROR);
        bus.ramWEN     = granted & bus.req_wen[gnt_q];
        bus.ramREN     = granted & bus.req_ren[gnt_q] & ~bus.req_wen[gnt_q];
        bus.ramaddr    = granted ? bus.req_addr[gnt_q]  : '0;
        bus.ramstore   = granted ? bus.req_store[gnt_q] : '0;
        bus.req_wait   = '0;
        bus.req_load   = '0;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_wait[i] = (bus.req_ren[i] | bus.req_wen[i])
                              & ~(completing && (gnt_q == IDX_W'(i)));
            if (completing && (gnt_q == IDX_W'(i))) begin
                bus.req_load[i] = bus.ramload;
            end
        end
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter (NREQ=4, MAXBURST=4): single read, fairness,
// locked burst, abort, RAM error retry and asynchronous reset mid-grant.
module tb_ram_arbiter;
    import cpu_types_pkg::*;

    localparam int NREQ     = 4;
    localparam int MAXBURST = 4;

    logic CLK = 1'b0;
    logic nRST;
    int   checks   = 0;
    int   failures = 0;

    ram_arbiter_if #(.NREQ(NREQ)) bus ();

    ram_arbiter #(.NREQ(NREQ), .MAXBURST(MAXBURST)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int order [5] = '{3, 0, 1, 2, 3};

        nRST          = 1'b0;
        bus.req_ren   = '0;
        bus.req_wen   = '0;
        bus.req_lock  = '0;
        bus.req_addr  = '0;
        bus.req_store = '0;
        bus.ramload   = '0;
        bus.ramstate  = FREE;
        #2;
        check("rst_gnt_valid", 32'(bus.gnt_valid), 32'h0);
        check("rst_ramREN",    32'(bus.ramREN),    32'h0);
        check("rst_ramWEN",    32'(bus.ramWEN),    32'h0);
        check("rst_ramaddr",   bus.ramaddr,        32'h0);
        check("rst_gnt_id",    32'(bus.gnt_id),    32'h0);
        check("rst_load",      32'(|bus.req_load), 32'h0);
        #10 nRST = 1'b1;

        // Single read from requester 2.
        tick();
        bus.req_ren[2]  = 1'b1;
        bus.req_addr[2] = 32'h40;
        #1;
        check("t1_wait_idle",   32'(bus.req_wait), 32'h4);
        check("t1_ren_idle",    32'(bus.ramREN),   32'h0);
        tick();
        bus.ramstate = BUSY;
        #1;
        check("t1_gnt_valid",   32'(bus.gnt_valid), 32'h1);
        check("t1_gnt_id",      32'(bus.gnt_id),    32'h2);
        check("t1_ramREN",      32'(bus.ramREN),    32'h1);
        check("t1_ramWEN",      32'(bus.ramWEN),    32'h0);
        check("t1_ramaddr",     bus.ramaddr,        32'h40);
        tick();
        check("t1_wait_busy",   32'(bus.req_wait),  32'h4);
        tick();
        bus.ramstate = ACCESS;
        bus.ramload  = 32'hDEADBEEF;
        #1;
        check("t1_wait_done",   32'(bus.req_wait),  32'h0);
        check("t1_load2",       bus.req_load[2],    32'hDEADBEEF);
        check("t1_load0",       bus.req_load[0],    32'h0);
        tick();
        bus.req_ren[2] = 1'b0;
        bus.ramstate   = FREE;
        #1;
        check("t1_released",    32'(bus.gnt_valid), 32'h0);
        check("t1_load_after",  bus.req_load[2],    32'h0);

        // Fairness: rr_ptr is 3 after the single read, so 3,0,1,2,3.
        bus.req_ren = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            bus.ramstate = ACCESS;
            #1;
            check($sformatf("t2_gnt_id_%0d", k), 32'(bus.gnt_id), 32'(order[k]));
            check($sformatf("t2_wait_%0d", k), 32'(bus.req_wait),
                  32'(4'b1111 & ~(4'b0001 << order[k])));
            tick();
            bus.ramstate = FREE;
            #1;
            check($sformatf("t2_idle_%0d", k), 32'(bus.gnt_valid), 32'h0);
        end
        bus.req_ren = '0;

        // Locked write burst on 1 with requester 3 also waiting (rr_ptr = 0).
        bus.req_wen[1]  = 1'b1;
        bus.req_lock[1] = 1'b1;
        bus.req_ren[3]  = 1'b1;
        bus.req_addr[1] = 32'h100;
        bus.req_addr[3] = 32'h300;
        tick();
        for (int b = 0; b < 4; b++) begin
            bus.req_store[1] = 32'hA000_0000 + 32'(b);
            bus.ramstate     = ACCESS;
            #1;
            check($sformatf("t3_valid_%0d", b), 32'(bus.gnt_valid), 32'h1);
            check($sformatf("t3_gnt_%0d", b),   32'(bus.gnt_id),    32'h1);
            check($sformatf("t3_wen_%0d", b),   32'(bus.ramWEN),    32'h1);
            check($sformatf("t3_ren_%0d", b),   32'(bus.ramREN),    32'h0);
            check($sformatf("t3_store_%0d", b), bus.ramstore,       32'hA000_0000 + 32'(b));
            check($sformatf("t3_wait_%0d", b),  32'(bus.req_wait),  32'h8);
            tick();
        end
        bus.ramstate = FREE;
        #1;
        check("t3_release",     32'(bus.gnt_valid), 32'h0);
        tick();
        check("t3_other_gnt",   32'(bus.gnt_id),    32'h3);
        check("t3_other_ren",   32'(bus.ramREN),    32'h1);
        check("t3_other_addr",  bus.ramaddr,        32'h300);
        check("t3_other_wait",  32'(bus.req_wait),  32'hA);
        bus.ramstate = ACCESS;
        tick();
        bus.req_ren[3] = 1'b0;
        bus.ramstate   = FREE;
        tick();
        check("t3_resume_gnt",  32'(bus.gnt_id),    32'h1);
        bus.req_store[1] = 32'hA000_0004;
        bus.ramstate     = ACCESS;
        #1;
        check("t3_store_4",     bus.ramstore,       32'hA000_0004);
        tick();
        bus.req_store[1] = 32'hA000_0005;
        bus.req_lock[1]  = 1'b0;
        #1;
        check("t3_valid_5",     32'(bus.gnt_valid), 32'h1);
        check("t3_store_5",     bus.ramstore,       32'hA000_0005);
        tick();
        bus.req_wen[1] = 1'b0;
        bus.ramstate   = FREE;
        #1;
        check("t3_done",        32'(bus.gnt_valid), 32'h0);

        // Abort: rr_ptr = 2, grantee 2 withdraws while RAM is BUSY.
        bus.req_ren[2]  = 1'b1;
        bus.req_ren[0]  = 1'b1;
        bus.req_addr[2] = 32'h240;
        bus.ramstate    = BUSY;
        tick();
        check("t4_gnt",         32'(bus.gnt_id),    32'h2);
        check("t4_ren",         32'(bus.ramREN),    32'h1);
        bus.req_ren[2] = 1'b0;
        #1;
        check("t4_ren_drop",    32'(bus.ramREN),    32'h0);
        check("t4_wait",        32'(bus.req_wait),  32'h1);
        tick();
        check("t4_idle",        32'(bus.gnt_valid), 32'h0);
        tick();
        check("t4_next_valid",  32'(bus.gnt_valid), 32'h1);
        check("t4_next_gnt",    32'(bus.gnt_id),    32'h0);
        bus.ramstate = ACCESS;
        tick();
        bus.req_ren[0] = 1'b0;
        bus.ramstate   = FREE;

        // RAM error for two cycles, then completion (rr_ptr = 1).
        bus.req_ren[1]  = 1'b1;
        bus.req_addr[1] = 32'h140;
        tick();
        bus.ramstate = ERROR;
        #1;
        check("t5_err_1",       32'(bus.ram_err),   32'h1);
        check("t5_wait_1",      32'(bus.req_wait),  32'h2);
        tick();
        check("t5_valid_2",     32'(bus.gnt_valid), 32'h1);
        check("t5_err_2",       32'(bus.ram_err),   32'h1);
        check("t5_ren_2",       32'(bus.ramREN),    32'h1);
        check("t5_wait_2",      32'(bus.req_wait),  32'h2);
        bus.ramstate = ACCESS;
        bus.ramload  = 32'h12345678;
        #1;
        check("t5_err_clear",   32'(bus.ram_err),   32'h0);
        check("t5_wait_done",   32'(bus.req_wait),  32'h0);
        check("t5_load",        bus.req_load[1],    32'h12345678);
        tick();
        bus.req_ren[1] = 1'b0;
        bus.ramstate   = FREE;
        #1;
        check("t5_idle",        32'(bus.gnt_valid), 32'h0);

        // Reset in the middle of a locked write grant (rr_ptr = 2).
        bus.req_wen[2]   = 1'b1;
        bus.req_lock[2]  = 1'b1;
        bus.req_addr[2]  = 32'h280;
        bus.req_store[2] = 32'h55;
        bus.ramstate     = BUSY;
        tick();
        check("t6_wen",         32'(bus.ramWEN),    32'h1);
        #1 nRST = 1'b0;
        #1;
        check("t6_wen_rst",     32'(bus.ramWEN),    32'h0);
        check("t6_valid_rst",   32'(bus.gnt_valid), 32'h0);
        check("t6_addr_rst",    bus.ramaddr,        32'h0);
        check("t6_store_rst",   bus.ramstore,       32'h0);
        check("t6_gnt_rst",     32'(bus.gnt_id),    32'h0);
        check("t6_err_rst",     32'(bus.ram_err),   32'h0);
        bus.req_wen[2]  = 1'b0;
        bus.req_lock[2] = 1'b0;
        bus.ramstate    = FREE;
        #1 nRST = 1'b1;
        // rr_ptr restarts at 0, so 1 wins over 3.
        bus.req_ren[1] = 1'b1;
        bus.req_ren[3] = 1'b1;
        tick();
        check("t6_ptr_reset",   32'(bus.gnt_id),    32'h1);
        bus.req_ren = '0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
